// File: rtl/reg_display_pager.sv
// Register display pager: debounced page button, snapshot/hold and 7-segment hex rendering.
// Optional auto-scroll enabled by defining REG_DISPLAY_PAGER_AUTO_SCROLL_EN.
module reg_display_pager #(
  parameter int NREGS        = 8,
  parameter int WIDTH        = 16,
  parameter int DEBOUNCE_CYC = 16,
  parameter int SCROLL_CYC   = 50000000
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic [NREGS*WIDTH-1:0] Regs,
  input  logic                   Next,
  input  logic                   Mode,
  input  logic                   Hold,
  input  logic                   AutoScroll,
  output logic [55:0]            Hex,
  output logic [5:0]             Page
);

  localparam int unsigned NPAGES_OV = (NREGS + 7) / 8;
  localparam int unsigned NDIG      = WIDTH / 4;
  localparam int unsigned CNTW      = $clog2(DEBOUNCE_CYC) + 1;
  localparam int unsigned AW        = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic            sync1, sync2;
  logic            db_lvl;
  logic [CNTW-1:0] db_cnt;
  logic            adv_p;
  logic            mode_r;
  logic            mode_chg;
  logic            tick;
  logic            advance;
  logic [5:0]      last_page;
  logic [WIDTH-1:0] snap [NREGS];
  logic [55:0]     hex_d;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      4'hA:    seg7 = 7'h08;
      4'hB:    seg7 = 7'h03;
      4'hC:    seg7 = 7'h46;
      4'hD:    seg7 = 7'h21;
      4'hE:    seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Synchroniser plus debouncer; the advance pulse is registered so it lands one edge after acceptance.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db_lvl <= 1'b0;
      db_cnt <= '0;
      adv_p  <= 1'b0;
    end else begin
      sync1 <= Next;
      sync2 <= sync1;
      adv_p <= 1'b0;
      if (sync2 == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == CNTW'(DEBOUNCE_CYC - 1)) begin
        db_cnt <= '0;
        db_lvl <= sync2;
        adv_p  <= sync2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign mode_chg = (Mode != mode_r);
  assign advance  = adv_p | tick;

`ifdef REG_DISPLAY_PAGER_AUTO_SCROLL_EN
  localparam int unsigned SW = $clog2(SCROLL_CYC);
  logic [SW-1:0] scnt;

  assign tick = AutoScroll && (scnt == SW'(SCROLL_CYC - 1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      scnt <= '0;
    end else if (!AutoScroll || adv_p || mode_chg || tick) begin
      scnt <= '0;
    end else begin
      scnt <= scnt + 1'b1;
    end
  end
`else
  logic unused_autoscroll;
  assign unused_autoscroll = AutoScroll;
  assign tick = 1'b0;
`endif

  always_comb begin
    last_page = mode_r ? 6'(NREGS - 1) : 6'(NPAGES_OV - 1);
  end

  // A mode change wins over any coincident advance.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mode_r <= 1'b0;
      Page   <= '0;
    end else begin
      mode_r <= Mode;
      if (mode_chg) begin
        Page <= '0;
      end else if (advance) begin
        Page <= (Page == last_page) ? '0 : Page + 6'd1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        snap[i] <= '0;
      end
    end else if (!Hold) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        snap[i] <= Regs[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    logic [31:0]      idx;
    logic [WIDTH-1:0] r;
    logic [31:0]      wide;
    hex_d = '1;
    idx   = '0;
    r     = '0;
    wide  = 32'(snap[Page[AW-1:0]]);
    for (int unsigned d = 0; d < 8; d++) begin
      if (!mode_r) begin
        idx = 32'(Page) * 32'd8 + 32'(7 - d);
        if (idx < NREGS) begin
          r = snap[idx[AW-1:0]];
          hex_d[7*d +: 7] = seg7(r[3:0]);
        end
      end else if (d < NDIG) begin
        hex_d[7*d +: 7] = seg7(wide[4*d +: 4]);
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int unsigned d = 0; d < 8; d++) begin
        Hex[7*d +: 7] <= (d < NREGS) ? 7'h40 : 7'h7F;
      end
    end else begin
      Hex <= hex_d;
    end
  end

endmodule
